// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// PipeSkidReg (module pipe_skid_reg)
//
// Purpose:
//   Inter-stage pipeline register with a valid/ready handshake and a
//   one-entry skid buffer. It takes the place of fixed per-stage registers
//   such as the EX->MEM register. Back-pressure from downstream is absorbed
//   by the skid entry, so in_ready_o is taken from registers only and never
//   from out_ready_i. A flush kills every held entry, and those entries then
//   show up as bubbles. A saturating counter records the cycles in which the
//   stage was stalled.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high
//   in_valid_i   upstream offers in_data_i / in_pc_i
//   in_ready_o   stage can accept an entry this cycle
//   in_data_i    upstream payload (DATA_W)
//   in_pc_i      upstream pc (PC_W)
//   flush_i      kill all held entries; a same-cycle input is discarded
//   out_valid_o  out_data_o / out_pc_o hold a live entry
//   out_ready_i  downstream consumes this cycle
//   out_data_o   oldest held payload (DATA_W)
//   out_pc_o     oldest held pc (PC_W)
//   out_bubble_o inverse of out_valid_o
//   occupancy_o  number of live entries held: 0, 1 or 2
//   stall_cnt_o  saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int unsigned     DATA_W   = 128,
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic              out_bubble_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              m_v_q,    m_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [PC_W-1:0]   m_pc_q,   m_pc_d;
  logic              s_v_q,    s_v_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [PC_W-1:0]   s_pc_q,   s_pc_d;
  logic [CNT_W-1:0]  stall_q,  stall_d;

  logic acc;
  logic drn;

  // The stage accepts only while the skid entry is free. This is a register
  // term, so ready has no combinational path from downstream. Reset is
  // folded in so that upstream sees the stage as busy during the reset cycle.
  assign in_ready_o = ~s_v_q & ~reset;
  assign acc        = in_valid_i & in_ready_o;
  assign drn        = m_v_q & out_ready_i;

  // Next-state selection. The branches are checked in priority order. A
  // flush clears only the valid bits, so the data and pc registers keep the
  // last value they held. Whenever skid is valid, in_ready_o is low, so the
  // skid-to-main move never happens in the same cycle as an accept.
  always_comb begin
    m_v_d    = m_v_q;
    m_data_d = m_data_q;
    m_pc_d   = m_pc_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_pc_d   = s_pc_q;

    if (flush_i) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (s_v_q && drn) begin
      m_data_d = s_data_q;
      m_pc_d   = s_pc_q;
      s_v_d    = 1'b0;
    end else if (!m_v_q && acc) begin
      m_v_d    = 1'b1;
      m_data_d = in_data_i;
      m_pc_d   = in_pc_i;
    end else if (drn && acc) begin
      m_data_d = in_data_i;
      m_pc_d   = in_pc_i;
    end else if (drn) begin
      m_v_d = 1'b0;
    end else if (m_v_q && acc) begin
      s_v_d    = 1'b1;
      s_data_d = in_data_i;
      s_pc_d   = in_pc_i;
    end
  end

  // The stall counter is independent of flush. It also counts the cycle in
  // which a flush is raised, as long as that cycle is itself a stall. It
  // sticks at all-ones rather than wrapping.
  always_comb begin
    stall_d = stall_q;
    if (m_v_q && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_v_q    <= 1'b0;
      m_data_q <= '0;
      m_pc_q   <= RESET_PC;
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      s_pc_q   <= '0;
      stall_q  <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
      m_pc_q   <= m_pc_d;
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      s_pc_q   <= s_pc_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid_o  = m_v_q;
  assign out_bubble_o = ~m_v_q;
  assign out_data_o   = m_data_q;
  assign out_pc_o     = m_pc_q;
  assign occupancy_o  = {1'b0, m_v_q} + {1'b0, s_v_q};
  assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// TbPipeSkidReg (module tb_pipe_skid_reg)
//
// Purpose:
//   Self-checking bench for pipe_skid_reg. The reference is a FIFO queue
//   that holds at most two entries. It also keeps the last value seen in the
//   main register and an unbounded stall count, which is clamped when it is
//   compared. The bench first runs directed scenarios and then a randomized
//   phase. Every output is compared against the model in every cycle.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int unsigned     DATA_W   = 128;
  localparam int unsigned     PC_W     = 64;
  localparam logic [PC_W-1:0] RESET_PC = 64'h8000_0000;
  localparam int unsigned     CNT_W    = 4;
  localparam int              CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic              clk;
  logic              reset;
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inData;
  logic [PC_W-1:0]   inPc;
  logic              flush;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;
  logic [PC_W-1:0]   outPc;
  logic              outBubble;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stallCnt;

  // Reference model state.
  entry_t modelQ[$];
  entry_t lastMain;
  int     modelStall;

  int checks;
  int errors;

  pipe_skid_reg #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .in_pc_i     (inPc),
    .flush_i     (flush),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .out_pc_o    (outPc),
    .out_bubble_o(outBubble),
    .occupancy_o (occupancy),
    .stall_cnt_o (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [DATA_W-1:0] observed,
                            input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs that apply to the coming rising edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [DATA_W-1:0] data,
                               input logic [PC_W-1:0] pc, input logic fl, input logic rdy);
    reset    = rst;
    inValid  = vld;
    inData   = data;
    inPc     = pc;
    flush    = fl;
    outReady = rdy;
  endtask

  // Compare every DUT output with the state the model holds now.
  task automatic checkOutput();
    logic expReady;
    int   expStall;
    expReady = !reset && (modelQ.size() < 2);
    expStall = (modelStall > CNT_MAX) ? CNT_MAX : modelStall;
    checkValue("in_ready",   DATA_W'(inReady),   DATA_W'(expReady));
    checkValue("out_valid",  DATA_W'(outValid),  DATA_W'(modelQ.size() != 0));
    checkValue("out_bubble", DATA_W'(outBubble), DATA_W'(modelQ.size() == 0));
    checkValue("occupancy",  DATA_W'(occupancy), DATA_W'(modelQ.size()));
    checkValue("stall_cnt",  DATA_W'(stallCnt),  DATA_W'(expStall));
    checkValue("out_pc",     DATA_W'(outPc),     DATA_W'(lastMain.pc));
    checkValue("out_data",   outData,            lastMain.data);
  endtask

  // Move the model to the state that follows the coming rising edge.
  task automatic updateModel();
    logic canAccept;
    canAccept = !reset && (modelQ.size() < 2);
    if (reset) begin
      modelQ.delete();
      modelStall = 0;
      lastMain   = '{data: '0, pc: RESET_PC};
    end else begin
      if (modelQ.size() != 0 && !outReady) modelStall++;
      if (flush) begin
        modelQ.delete();
      end else begin
        if (modelQ.size() != 0 && outReady) void'(modelQ.pop_front());
        if (inValid && canAccept) modelQ.push_back('{data: inData, pc: inPc});
      end
      if (modelQ.size() != 0) lastMain = modelQ[0];
    end
  endtask

  task automatic runCycle(input logic rst, input logic vld, input logic [PC_W-1:0] pc,
                          input logic fl, input logic rdy);
    logic [DATA_W-1:0] data;
    data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    applyStimulus(rst, vld, data, pc, fl, rdy);
    #1;
    checkOutput();
    updateModel();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    modelStall = 0;
    lastMain   = '{data: '0, pc: RESET_PC};
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset held for two cycles, then released.
    runCycle(1, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0);
    checkValue("reset_in_ready", DATA_W'(inReady), '0);
    runCycle(0, 0, 0, 0, 0);
    checkValue("post_reset_pc", DATA_W'(outPc), DATA_W'(RESET_PC));
    checkValue("post_reset_ready", DATA_W'(inReady), DATA_W'(1));

    // Streaming at one entry per cycle.
    runCycle(0, 1, 64'h100, 0, 1);
    runCycle(0, 1, 64'h104, 0, 1);
    checkValue("stream_pc0", DATA_W'(outPc), DATA_W'(64'h100));
    runCycle(0, 1, 64'h108, 0, 1);
    checkValue("stream_pc1", DATA_W'(outPc), DATA_W'(64'h104));
    checkValue("stream_occ", DATA_W'(occupancy), DATA_W'(1));
    runCycle(0, 0, 0, 0, 1);
    checkValue("stream_pc2", DATA_W'(outPc), DATA_W'(64'h108));

    // Back-pressure fills the skid entry; entries then drain in order.
    runCycle(0, 1, 64'h200, 0, 0);
    runCycle(0, 1, 64'h204, 0, 0);
    runCycle(0, 0, 0, 0, 0);
    checkValue("bp_occ", DATA_W'(occupancy), DATA_W'(2));
    checkValue("bp_ready", DATA_W'(inReady), '0);
    runCycle(0, 1, 64'h2ff, 0, 0);
    runCycle(0, 0, 0, 0, 0);
    checkValue("bp_stall", DATA_W'(stallCnt), DATA_W'(3));
    checkValue("bp_pc_a", DATA_W'(outPc), DATA_W'(64'h200));
    runCycle(0, 0, 0, 0, 1);
    runCycle(0, 0, 0, 0, 1);
    checkValue("bp_pc_b", DATA_W'(outPc), DATA_W'(64'h204));
    checkValue("bp_ready_back", DATA_W'(inReady), DATA_W'(1));
    runCycle(0, 0, 0, 0, 1);

    // A flush with a same-cycle input leaves the stage empty.
    runCycle(0, 1, 64'h220, 0, 0);
    runCycle(0, 1, 64'h224, 0, 0);
    runCycle(0, 1, 64'h300, 1, 0);
    runCycle(0, 0, 0, 0, 1);
    checkValue("flush_valid", DATA_W'(outValid), '0);
    checkValue("flush_pc_kept", DATA_W'(outPc), DATA_W'(64'h220));
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 1);

    // Reset while full and while downstream is ready.
    runCycle(0, 1, 64'h400, 0, 0);
    runCycle(0, 1, 64'h404, 0, 0);
    runCycle(1, 0, 0, 0, 1);
    runCycle(0, 0, 0, 0, 1);
    checkValue("midreset_pc", DATA_W'(outPc), DATA_W'(RESET_PC));
    checkValue("midreset_occ", DATA_W'(occupancy), '0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 1);

    // The counter saturates and is not cleared by a flush.
    runCycle(0, 1, 64'h500, 0, 0);
    for (int i = 0; i < 20; i++) runCycle(0, 0, 0, 0, 0);
    checkValue("sat_stall", DATA_W'(stallCnt), DATA_W'(CNT_MAX));
    runCycle(0, 0, 0, 1, 0);
    runCycle(0, 0, 0, 0, 0);
    checkValue("sat_after_flush", DATA_W'(stallCnt), DATA_W'(CNT_MAX));

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      runCycle(($urandom_range(63) == 0), ($urandom_range(3) != 0),
               {$urandom, $urandom}, ($urandom_range(15) == 0),
               ($urandom_range(2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
